// File: rtl/mma_arb_pkg.sv
// rtl/mma_arb_pkg.sv - shared state encoding, channel map and defaults for the ICB arbiter
package mma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int CH_IA     = 0;
    localparam int CH_WEIGHT = 1;
    localparam int CH_BIAS   = 2;
    localparam int CH_QUANT  = 3;
    localparam int CH_OA     = 4;

    localparam int DEFAULT_NUM_REQ = 5;

endpackage

// File: rtl/mma_rr_picker.sv
// rtl/mma_rr_picker.sv - combinational round-robin picker; search starts one past last_idx
module mma_rr_picker #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        // Offset NUM_REQ lands back on last_idx, so it is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_idx) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!valid && req_vec[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/mma_icb_arbiter.sv
// rtl/mma_icb_arbiter.sv - priority round-robin ICB grant arbiter (IDLE/GRANT/RELEASE)
// Optional grant watchdog enabled by MMA_ARB_WATCHDOG_EN.
module mma_icb_arbiter
    import mma_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int REG_WIDTH  = 32,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic [NUM_REQ-1:0]         prio_mask,
    input  logic                       err_clr,
    output logic [NUM_REQ-1:0]         granted,
    output logic [$clog2(NUM_REQ)-1:0] icb_sel,
    output logic                       busy,
    output logic [REG_WIDTH-1:0]       txn_count,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   granted_q, granted_d;
    logic [IDX_W-1:0]     icb_sel_q, icb_sel_d;
    logic [IDX_W-1:0]     last_winner_q, last_winner_d;
    logic [REG_WIDTH-1:0] txn_count_q, txn_count_d;

    logic             hp_valid, all_valid;
    logic [IDX_W-1:0] hp_idx, all_idx, winner;
    logic             done_win;
    logic             timeout_hit;

    mma_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_hp (
        .req_vec  (req & prio_mask),
        .last_idx (last_winner_q),
        .valid    (hp_valid),
        .winner   (hp_idx)
    );

    mma_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_all (
        .req_vec  (req),
        .last_idx (last_winner_q),
        .valid    (all_valid),
        .winner   (all_idx)
    );

    assign winner   = hp_valid ? hp_idx : all_idx;
    assign done_win = done[icb_sel_q];

`ifdef MMA_ARB_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign timeout_hit = (state_q == GRANT) && !done_win
                         && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    always_comb begin
        wdt_cnt_d     = wdt_cnt_q;
        timeout_err_d = timeout_err_q;
        // Held at zero outside GRANT, so every grant starts counting from zero.
        if (state_q != GRANT) begin
            wdt_cnt_d = '0;
        end else if (!timeout_hit) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdt_cnt_q     <= wdt_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_wdt_cfg;

    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_wdt_cfg = err_clr ^ (WDT_CYCLES > 0);
`endif

    always_comb begin
        state_d       = state_q;
        granted_d     = granted_q;
        icb_sel_d     = icb_sel_q;
        last_winner_d = last_winner_q;
        txn_count_d   = txn_count_q;
        unique case (state_q)
            IDLE: begin
                if (arb_en && (|req)) begin
                    state_d       = GRANT;
                    granted_d     = NUM_REQ'(1) << winner;
                    icb_sel_d     = winner;
                    last_winner_d = winner;
                end
            end
            GRANT: begin
                // Only the winner's done ends the grant; dropped req is ignored.
                if (done_win) begin
                    state_d     = RELEASE;
                    granted_d   = '0;
                    txn_count_d = txn_count_q + REG_WIDTH'(1);
                end else if (timeout_hit) begin
                    state_d   = RELEASE;
                    granted_d = '0;
                end
            end
            RELEASE: begin
                state_d   = IDLE;
                granted_d = '0;
            end
            default: begin
                state_d   = IDLE;
                granted_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            granted_q     <= '0;
            icb_sel_q     <= '0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
            txn_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            granted_q     <= granted_d;
            icb_sel_q     <= icb_sel_d;
            last_winner_q <= last_winner_d;
            txn_count_q   <= txn_count_d;
        end
    end

    assign granted   = granted_q;
    assign icb_sel   = icb_sel_q;
    assign busy      = (state_q == GRANT) || (state_q == RELEASE);
    assign txn_count = txn_count_q;

endmodule
